mux8_rr_arbiter: RTL

Round-robin arbiter and select controller for the 8:1 multiplexer `mux8`. Up to eight requesters compete for the single mux output `y`. The block grants exactly one at a time, drives the mux select `s` from the granted index, and enforces a bounded hold time so no requester can starve the others. It sits directly in front of `mux8`: `sel` connects to `s`, and `busy` qualifies `y`.

---
 rtl/mux8_arb_pkg.sv | 18 +
 rtl/rr_priority8.sv | 31 +++
 rtl/mux8_rr_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/mux8_arb_pkg.sv
// Shared types and constants for the mux8 round-robin arbiter.
// Requester vector, FSM state and one-hot helper live here.
package mux8_arb_pkg;

  localparam int N  = 8;
  localparam int SW = 3;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef logic [N-1:0] req_vec_t;

  function automatic req_vec_t onehot(
    input logic [SW-1:0] i
  );
    onehot = req_vec_t'(1) << i;
  endfunction

endpackage

// File: rtl/rr_priority8.sv
// Rotating first-one search over eight requests, starting at ptr.
// Optionally masks one index (the releasing holder) out of the scan.
module rr_priority8
  import mux8_arb_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  input  logic [2:0] mask_idx,
  input  logic       mask_en,
  output logic       found,
  output logic [2:0] idx
);

  logic [7:0] m;
  logic [2:0] k;

  always_comb begin
    found = 1'b0;
    idx   = ptr;
    k     = ptr;
    m     = req & ~(mask_en ? onehot(mask_idx) : 8'h00);
    for (int i = 0; i < 8; i++) begin
      k = ptr + 3'(i);
      if (!found && m[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin grant/select controller in front of mux8.
// Bounded hold time; release re-arbitrates with no idle bubble.
module mux8_rr_arbiter #(
  parameter int N        = 8,
  parameter int SW       = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] sel,
  output logic          busy
);
  import mux8_arb_pkg::*;

  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] LAST =
    (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

  arb_state_t    state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          busy_q, busy_d;

  logic          mask_en;
  logic          found;
  logic [2:0]    pick;
  logic          hold;

  rr_priority8 u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .mask_idx (sel_q),
    .mask_en  (mask_en),
    .found    (found),
    .idx      (pick)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    mask_en = 1'b0;
    hold    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = onehot(pick);
          sel_d   = pick;
          busy_d  = 1'b1;
          cnt_d   = '0;
          ptr_d   = pick + 3'd1;
        end
      end
      GRANT: begin
        hold = req[sel_q] &&
               ((MAX_HOLD == 0) || (cnt_q != LAST));
        // timeout keeps the holder in the scan so it can be re-granted
        mask_en = !req[sel_q];
        if (hold) begin
          cnt_d = cnt_q + 1'b1;
        end else if (found) begin
          grant_d = onehot(pick);
          sel_d   = pick;
          busy_d  = 1'b1;
          cnt_d   = '0;
          ptr_d   = pick + 3'd1;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;

endmodule
